mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle main control FSM for the Mini-MIPS core. It sequences instruction fetch, decode, execute, memory access and write-back over a shared memory port with a ready handshake. Each cycle it drives the datapath select and enable lines, including the immediate-extension mode for the immediate unit. It sits between the instruction/data memory port and the register file / ALU / PC datapath.

## Interface
- No parameters.
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_ready  input  1  memory port completed the current access this cycle
- mem_rdata_op  input  6  mem_rdata[31:26]; latched as opcode when FETCH and mem_ready
- state  output  3  RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
- mem_read / mem_write  output  1  memory port request, held until mem_ready
- ir_write / pc_write / pc_write_cond  output  1  IR load, unconditional PC load, PC load if ALU zero
- pc_src  output  2  00 ALU result, 01 ALUOut register, 10 jump target
- alu_src_a  output  1  0 PC, 1 rs
- alu_src_b  output  2  00 rt, 01 const 4, 10 imm_ext, 11 imm_ext<<2
- alu_op  output  2  00 add, 01 sub, 10 use funct, 11 use opcode (logical-imm)
- imm_mode  output  2  00 sign-extend, 01 zero-extend, 10 imm<<16 (lui)
- reg_dst / mem_to_reg / reg_write  output  1  dest rd(1)/rt(0), WB from memory(1)/ALUOut(0), RF write enable
- illegal  output  1  one-cycle pulse on unsupported opcode
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Supported opcodes: R 0x00, j 0x02, beq 0x04, addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B; anything else is illegal.
- Opcode register (6 b, reset 0) loads only in FETCH when mem_ready=1.
- All outputs are combinational from state and the opcode register; any signal not listed for a state is 0.
- RESET: all outputs 0; next state FETCH unconditionally.
- FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write equal mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, imm_mode=00 (branch target into ALUOut).
  - j: pc_write=1, pc_src=10, instr_done=1, next FETCH.
  - Illegal opcode: illegal=1, instr_done=1, next FETCH.
  - Otherwise next EXEC.
- EXEC:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB.
  - addi/lw/sw: alu_src_a=1, alu_src_b=10, imm_mode=00, alu_op=00. addi goes to WB; lw/sw go to MEM.
  - andi/ori: alu_src_a=1, alu_src_b=10, imm_mode=01, alu_op=11; next WB.
  - lui: alu_src_a=1, alu_src_b=10, imm_mode=10, alu_op=11; next WB. The ALU passes B for lui.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1; next FETCH.
- MEM: lw drives mem_read=1; sw drives mem_write=1. Stay while mem_ready=0. On mem_ready, lw goes to WB; sw raises instr_done and goes to FETCH.
- WB: reg_write=1. lw: mem_to_reg=1, reg_dst=0. R: reg_dst=1. Immediate ops: reg_dst=0. instr_done=1; next FETCH.
- Unused state encodings 6 and 7 go to FETCH with all outputs 0.

## Timing
- Cycle counts with mem_ready always 1:
  - j and illegal: 2
  - beq: 3
  - R, addi, andi, ori, lui, sw: 4
  - lw: 5
  - Each wait cycle (mem_ready=0) in FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- mem_read and mem_write never assert in the same cycle.
- rst_n low at any time, including mid-wait in MEM: state=RESET and opcode=0 immediately (asynchronous). Outputs are 0 while rst_n is low. The first FETCH is in the cycle after the first rising edge with rst_n high.
- An opcode change on mem_rdata_op outside the FETCH/mem_ready cycle has no effect.

## Test plan
- Reset release, mem_ready=1, opcode 0x00: states 0,1,2,3,5,1. reg_write=1 and reg_dst=1 in WB. instr_done pulses once.
- lw (0x23) with mem_ready low for 2 cycles in MEM: mem_read held 3 cycles in MEM, then WB with mem_to_reg=1. Total 7 cycles.
- andi 0x0C, then ori 0x0D, then lui 0x0F: imm_mode in EXEC is 01, 01, 10. imm_mode is 00 in every DECODE.
- beq 0x04: pc_write_cond=1 and pc_src=01 only in EXEC, then FETCH. j 0x02: pc_write=1 and pc_src=10 in DECODE, 2 cycles total.
- Opcode 0x3F: illegal=1 for exactly one cycle in DECODE. No reg_write or mem_write at any point, then FETCH.
- sw with rst_n asserted during a MEM wait: mem_write drops to 0 asynchronously. After release, RESET then FETCH, and the opcode register reads 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle main control FSM for the Mini-MIPS core.
// Sequences fetch/decode/exec/mem/wb over a shared memory port with a ready handshake.
`default_nettype none

module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ready,
  input  logic [5:0] mem_rdata_op,
  output logic [2:0] state,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_mode,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic       op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      opcode_q <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && mem_ready)
        opcode_q <= mem_rdata_op;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (opcode_q)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = S_FETCH;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    imm_mode      = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut during decode
        alu_src_b = 2'b11;
        if (opcode_q == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (!op_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_WB;
        case (opcode_q)
          OP_R: alu_op = 2'b10;
          OP_ADDI: alu_src_b = 2'b10;
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_ANDI, OP_ORI: begin
            alu_src_b = 2'b10;
            imm_mode  = 2'b01;
            alu_op    = 2'b11;
          end
          OP_LUI: begin
            alu_src_b = 2'b10;
            imm_mode  = 2'b10;
            alu_op    = 2'b11;
          end
          OP_BEQ: begin
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (opcode_q == OP_LW);
        mem_write = (opcode_q == OP_SW);
        if (!mem_ready)
          state_d = S_MEM;
        else if (opcode_q == OP_LW)
          state_d = S_WB;
        else begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode_q == OP_R);
        mem_to_reg = (opcode_q == OP_LW);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized instruction streams checked
// against an instruction-level model of the expected per-cycle control outputs.
`default_nettype none

module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] mem_rdata_op;
  logic [2:0] state;
  logic       mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op, imm_mode;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal, instr_done;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .mem_rdata_op(mem_rdata_op),
    .state(state), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_mode(imm_mode),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mr, mw, irw, pcw, pcwc;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb, aop, imm;
    logic       rd, m2r, rw, ill, done;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic [5:0] op;
    outs_t      exp;
    string      tag;
  } cyc_t;

  outs_t obs;
  assign obs = {state, mem_read, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, imm_mode, reg_dst, mem_to_reg, reg_write,
                illegal, instr_done};

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input outs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [5:0] op, input outs_t o, input string tag);
    cyc_t c;
    c.rdy = rdy; c.op = op; c.exp = o; c.tag = tag;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from the opcode rules.
  task automatic plan(input logic [5:0] opc, input int fwait, input int mwait);
    outs_t o;
    string t;
    bit legal, is_mem;
    t = $sformatf("op%02h", opc);
    legal  = opc inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    is_mem = opc inside {6'h23, 6'h2B};
    for (int i = 0; i < fwait; i++) begin
      o = '0; o.st = 3'd1; o.mr = 1'b1; o.asb = 2'b01;
      push(1'b0, 6'($urandom), o, {t, "_fetchwait"});
    end
    o = '0; o.st = 3'd1; o.mr = 1'b1; o.asb = 2'b01; o.irw = 1'b1; o.pcw = 1'b1;
    push(1'b1, opc, o, {t, "_fetch"});
    o = '0; o.st = 3'd2; o.asb = 2'b11;
    if (opc == 6'h02) begin
      o.pcw = 1'b1; o.pcs = 2'b10; o.done = 1'b1;
      push(1'($urandom), 6'($urandom), o, {t, "_decode_j"});
      return;
    end
    if (!legal) begin
      o.ill = 1'b1; o.done = 1'b1;
      push(1'($urandom), 6'($urandom), o, {t, "_decode_ill"});
      return;
    end
    push(1'($urandom), 6'($urandom), o, {t, "_decode"});
    o = '0; o.st = 3'd3; o.asa = 1'b1;
    case (opc)
      6'h00: o.aop = 2'b10;
      6'h0C, 6'h0D: begin o.asb = 2'b10; o.imm = 2'b01; o.aop = 2'b11; end
      6'h0F: begin o.asb = 2'b10; o.imm = 2'b10; o.aop = 2'b11; end
      6'h04: begin o.aop = 2'b01; o.pcwc = 1'b1; o.pcs = 2'b01; o.done = 1'b1; end
      default: o.asb = 2'b10;
    endcase
    push(1'($urandom), 6'($urandom), o, {t, "_exec"});
    if (opc == 6'h04) return;
    if (is_mem) begin
      for (int i = 0; i <= mwait; i++) begin
        o = '0; o.st = 3'd4; o.mr = (opc == 6'h23); o.mw = (opc == 6'h2B);
        o.done = (i == mwait) && (opc == 6'h2B);
        push(i == mwait, 6'($urandom), o, {t, "_mem"});
      end
      if (opc == 6'h2B) return;
    end
    o = '0; o.st = 3'd5; o.rw = 1'b1; o.rd = (opc == 6'h00); o.m2r = (opc == 6'h23);
    o.done = 1'b1;
    push(1'($urandom), 6'($urandom), o, {t, "_wb"});
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      mem_rdata_op = c.op;
      #2;
      check(c.tag, c.exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  logic [5:0] legal_ops [9] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  outs_t zero_o;

  initial begin
    zero_o = '0;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    mem_rdata_op = 6'h00;
    @(posedge clk); #1;
    check("reset_held", zero_o);
    rst_n = 1'b1;
    push(1'b1, 6'h2B, zero_o, "reset_release");
    plan(6'h00, 0, 0);
    run_all();

    plan(6'h23, 0, 2);
    plan(6'h0C, 0, 0);
    plan(6'h0D, 1, 0);
    plan(6'h0F, 0, 0);
    plan(6'h04, 0, 0);
    plan(6'h02, 0, 0);
    plan(6'h3F, 0, 0);
    plan(6'h08, 2, 0);
    plan(6'h2B, 0, 1);
    run_all();

    // sw interrupted by an asynchronous reset during a memory wait
    plan(6'h2B, 0, 3);
    run_n(4);
    mem_ready = 1'b0;
    #2;
    check("sw_mem_before_rst", q[0].exp);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", zero_o);
    q.delete();
    @(posedge clk); #1;
    check("rst_low_after_edge", zero_o);
    rst_n = 1'b1;
    push(1'b1, 6'h00, zero_o, "reset_release2");
    plan(6'h0D, 0, 0);
    run_all();

    for (int k = 0; k < 60; k++) begin
      logic [5:0] opc;
      opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 8)];
      plan(opc, $urandom_range(0, 2), $urandom_range(0, 2));
      run_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
